// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the system bus arbiter: master count, index width,
// master indices, watchdog default and the active-low enable levels.
package bus_rr_arbiter_pkg;

  localparam int NUM_MASTERS     = 4;
  localparam int OWNER_W         = 2;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W_DEFAULT   = 8;

  localparam logic [OWNER_W-1:0] BUS_MASTER_0 = 2'd0;  // CPU instruction side
  localparam logic [OWNER_W-1:0] BUS_MASTER_1 = 2'd1;  // CPU data side
  localparam logic [OWNER_W-1:0] BUS_MASTER_2 = 2'd2;  // DMA master A
  localparam logic [OWNER_W-1:0] BUS_MASTER_3 = 2'd3;  // DMA master B

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_e;

  function automatic logic [NUM_MASTERS-1:0] owner_mask(input logic [OWNER_W-1:0] idx);
    return NUM_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_pick.sv
// Combinational round-robin picker: scans from last_i+1 around to last_i and
// returns the first set bit of elig_i, so last_i always has the lowest priority.
module bus_rr_pick
  import bus_rr_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] elig_i,
  input  logic [OWNER_W-1:0]     last_i,
  output logic [OWNER_W-1:0]     winner_o,
  output logic                   found_o
);

  logic [OWNER_W-1:0] idx;

  // Walking from the farthest candidate to the nearest lets the nearest
  // eligible master overwrite the others.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    winner_o = last_i;
    found_o  = 1'b0;
    idx      = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = last_i + OWNER_W'(k);
      if (elig_i[idx]) begin
        winner_o = idx;
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared system bus with active-low request/grant
// handshakes and a watchdog that revokes a grant whose slave never goes ready.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req_,
  input  logic                   bus_rdy_,
  output logic [NUM_MASTERS-1:0] m_grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   owner_vld,
  output logic                   timeout_err,
  output logic [OWNER_W-1:0]     err_owner
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [OWNER_W-1:0]     err_owner_q, err_owner_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]       wdog_q, wdog_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] revoke;
  logic [NUM_MASTERS-1:0] elig;
  logic                   release_ev;
  logic                   timeout_ev;
  logic [OWNER_W-1:0]     pick_winner;
  logic                   pick_found;

  assign req        = ~m_req_;
  assign release_ev = (state_q == ST_GRANTED) && (m_req_[owner_q] == DISABLE_);
  // A release on the same edge as the timeout is a normal hand-back, not an error.
  assign timeout_ev = (state_q == ST_GRANTED) && !release_ev && (wdog_q == TO_CNT);
  assign revoke     = timeout_ev ? owner_mask(owner_q) : '0;
  assign elig       = req & ~mask_q & ~revoke;

  bus_rr_pick u_pick (
    .elig_i   (elig),
    .last_i   (owner_q),
    .winner_o (pick_winner),
    .found_o  (pick_found)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    grnt_d        = grnt_q;
    timeout_err_d = timeout_ev;
    err_owner_d   = timeout_ev ? owner_q : err_owner_q;
    // A masked master stays locked out until it withdraws its request.
    mask_d        = (mask_q & req) | revoke;

    if (state_q == ST_IDLE || release_ev || timeout_ev) begin
      if (pick_found) begin
        state_d             = ST_GRANTED;
        owner_d             = pick_winner;
        grnt_d              = {NUM_MASTERS{DISABLE_}};
        grnt_d[pick_winner] = ENABLE_;
      end else begin
        state_d = ST_IDLE;
        grnt_d  = {NUM_MASTERS{DISABLE_}};
      end
    end

    if (grnt_d != grnt_q || bus_rdy_ == ENABLE_) begin
      wdog_d = '0;
    end else if (state_q == ST_GRANTED && wdog_q != '1) begin
      wdog_d = wdog_q + CNT_W'(1);
    end else begin
      wdog_d = wdog_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      grnt_q        <= {NUM_MASTERS{DISABLE_}};
      owner_q       <= BUS_MASTER_0;
      err_owner_q   <= BUS_MASTER_0;
      timeout_err_q <= 1'b0;
      mask_q        <= '0;
      wdog_q        <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      state_q       <= state_d;
      grnt_q        <= grnt_d;
      owner_q       <= owner_d;
      err_owner_q   <= err_owner_d;
      timeout_err_q <= timeout_err_d;
      mask_q        <= mask_d;
      wdog_q        <= wdog_d;
    end
  end

  assign m_grnt_     = grnt_q;
  assign owner       = owner_q;
  assign owner_vld   = (state_q == ST_GRANTED);
  assign timeout_err = timeout_err_q;
  assign err_owner   = err_owner_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: a cycle model of the arbitration rules is
// compared every cycle, and literal expectations pin the key scenarios.
module tb_bus_rr_arbiter;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk;
  logic       reset;
  logic [3:0] m_req_;
  logic       bus_rdy_;
  logic [3:0] m_grnt_;
  logic [1:0] owner;
  logic       owner_vld;
  logic       timeout_err;
  logic [1:0] err_owner;

  int n_checks = 0;
  int n_fail   = 0;

  bus_rr_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .m_req_      (m_req_),
    .bus_rdy_    (bus_rdy_),
    .m_grnt_     (m_grnt_),
    .owner       (owner),
    .owner_vld   (owner_vld),
    .timeout_err (timeout_err),
    .err_owner   (err_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       mdl_vld   = 1'b0;
  int       mdl_owner = 0;
  int       mdl_cnt   = 0;
  bit [3:0] mdl_mask  = 4'b0000;
  bit       mdl_terr  = 1'b0;
  int       mdl_eown  = 0;

  function automatic logic [3:0] mdl_grnt();
    logic [3:0] g;
    g = 4'b1111;
    if (mdl_vld) g[mdl_owner] = 1'b0;
    return g;
  endfunction

  always @(posedge clk or negedge reset) begin : model_step
    int       win;
    int       cand;
    bit       rel;
    bit       to;
    bit       nv;
    int       no;
    bit [3:0] nm;
    if (!reset) begin
      mdl_vld   <= 1'b0;
      mdl_owner <= 0;
      mdl_cnt   <= 0;
      mdl_mask  <= 4'b0000;
      mdl_terr  <= 1'b0;
      mdl_eown  <= 0;
    end else begin
      rel = mdl_vld && m_req_[mdl_owner];
      to  = mdl_vld && !rel && (mdl_cnt == TIMEOUT);
      win = -1;
      for (int k = 1; k <= 4; k++) begin
        cand = (mdl_owner + k) % 4;
        if (win < 0 && !m_req_[cand] && !mdl_mask[cand] && !(to && cand == mdl_owner))
          win = cand;
      end
      nv = mdl_vld;
      no = mdl_owner;
      if (!mdl_vld || rel || to) begin
        if (win >= 0) begin
          nv = 1'b1;
          no = win;
        end else begin
          nv = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) nm[i] = mdl_mask[i] && !m_req_[i];
      if (to) nm[mdl_owner] = 1'b1;
      if ((nv != mdl_vld) || (nv && no != mdl_owner) || !bus_rdy_)
        mdl_cnt <= 0;
      else if (mdl_vld && mdl_cnt < CNT_MAX)
        mdl_cnt <= mdl_cnt + 1;
      mdl_vld   <= nv;
      mdl_owner <= no;
      mdl_mask  <= nm;
      mdl_terr  <= to;
      if (to) mdl_eown <= mdl_owner;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("cyc_grnt",        32'(m_grnt_),     32'(mdl_grnt()));
    check("cyc_owner",       32'(owner),       32'(mdl_owner));
    check("cyc_owner_vld",   32'(owner_vld),   32'(mdl_vld));
    check("cyc_timeout_err", 32'(timeout_err), 32'(mdl_terr));
    check("cyc_err_owner",   32'(err_owner),   32'(mdl_eown));
    check("cyc_grant_onehot", 32'($countones(~m_grnt_) <= 1), 32'(1));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int exp_a[4];
  int exp_b[4];
  int cur;
  int waited;
  bit seen;

  initial begin
    reset    = 1'b1;
    m_req_   = 4'b1111;
    bus_rdy_ = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_grnt",      32'(m_grnt_),     32'h0000000f);
    check("rst_owner",     32'(owner),       32'd0);
    check("rst_owner_vld", 32'(owner_vld),   32'd0);
    check("rst_terr",      32'(timeout_err), 32'd0);
    check("rst_err_owner", 32'(err_owner),   32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    tick(1);

    // Single request on an idle bus: one-cycle grant, held while requesting.
    m_req_ = 4'b1110;
    tick(1);
    check("t1_grnt",  32'(m_grnt_),   32'h0000000e);
    check("t1_owner", 32'(owner),     32'd0);
    check("t1_vld",   32'(owner_vld), 32'd1);
    tick(3);
    check("t1_hold",  32'(m_grnt_),   32'h0000000e);

    // All masters request; each owner releases for one cycle.
    m_req_ = 4'b0000;
    tick(3);
    exp_a = '{1, 2, 3, 0};
    cur = 0;
    for (int i = 0; i < 4; i++) begin
      m_req_[cur] = 1'b1;
      tick(1);
      check("t2_rr_owner", 32'(owner),     32'(exp_a[i]));
      check("t2_rr_vld",   32'(owner_vld), 32'd1);
      m_req_[cur] = 1'b0;
      cur = exp_a[i];
      tick(3);
    end

    // Owner 2 releases with nobody else requesting; owner is retained.
    m_req_ = 4'b1011;
    tick(1);
    check("t3_owner2", 32'(owner), 32'd2);
    tick(2);
    m_req_ = 4'b1111;
    tick(1);
    check("t3_idle_grnt",  32'(m_grnt_),   32'h0000000f);
    check("t3_idle_vld",   32'(owner_vld), 32'd0);
    check("t3_idle_owner", 32'(owner),     32'd2);
    tick(2);
    m_req_ = 4'b1011;
    tick(1);
    check("t3_regrant", 32'(m_grnt_), 32'h0000000b);
    m_req_ = 4'b1111;
    tick(1);

    // Watchdog: master 1 granted, slave never ready, master 3 waiting.
    bus_rdy_ = 1'b1;
    m_req_   = 4'b1101;
    tick(1);
    check("t4_owner1", 32'(owner), 32'd1);
    m_req_ = 4'b0101;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < 20) begin
      tick(1);
      waited++;
      if (timeout_err) seen = 1'b1;
    end
    check("t4_timeout_seen", 32'(seen), 32'd1);
    // Count reaches TIMEOUT after TIMEOUT busy cycles; revoke on the following edge.
    check("t4_timeout_latency", 32'(waited), 32'(TIMEOUT + 1));
    check("t4_err_owner", 32'(err_owner), 32'd1);
    check("t4_new_owner", 32'(owner),     32'd3);
    check("t4_grnt",      32'(m_grnt_),   32'h00000007);
    bus_rdy_ = 1'b0;
    tick(1);
    check("t4_pulse_once", 32'(timeout_err), 32'd0);
    m_req_ = 4'b1101;
    tick(1);
    check("t4_masked_idle", 32'(owner_vld), 32'd0);
    tick(3);
    check("t4_still_masked", 32'(owner_vld), 32'd0);
    m_req_ = 4'b1111;
    tick(1);
    m_req_ = 4'b1101;
    tick(1);
    check("t4_unmask_owner", 32'(owner),     32'd1);
    check("t4_unmask_vld",   32'(owner_vld), 32'd1);

    // Release lands on the same edge as the timeout: release wins.
    bus_rdy_ = 1'b1;
    tick(TIMEOUT);
    m_req_ = 4'b1111;
    tick(1);
    check("t4b_no_pulse",  32'(timeout_err), 32'd0);
    check("t4b_idle",      32'(owner_vld),   32'd0);
    check("t4b_err_stick", 32'(err_owner),   32'd1);
    m_req_ = 4'b1101;
    tick(1);
    check("t4b_not_masked", 32'(owner_vld), 32'd1);
    m_req_   = 4'b1111;
    bus_rdy_ = 1'b0;
    tick(1);

    // Periodic ready keeps the watchdog from firing.
    m_req_ = 4'b1110;
    tick(1);
    check("t5_owner0", 32'(owner), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus_rdy_ = (i % 5 == 4) ? 1'b0 : 1'b1;
      tick(1);
      if (timeout_err) seen = 1'b1;
    end
    check("t5_no_timeout", 32'(seen), 32'd0);
    bus_rdy_ = 1'b0;
    m_req_   = 4'b1111;
    tick(1);

    // All four request with owner 3: order 0,1,2,3.
    m_req_ = 4'b0111;
    tick(1);
    check("t6_owner3", 32'(owner), 32'd3);
    m_req_ = 4'b0000;
    tick(2);
    exp_b = '{0, 1, 2, 3};
    cur = 3;
    for (int i = 0; i < 4; i++) begin
      m_req_[cur] = 1'b1;
      tick(1);
      check("t6_rr_owner", 32'(owner), 32'(exp_b[i]));
      m_req_[cur] = 1'b0;
      cur = exp_b[i];
      tick(2);
    end
    m_req_ = 4'b1111;
    tick(1);

    // Reset mid-grant: grants drop without a clock; priority restarts at master 1.
    m_req_ = 4'b1011;
    tick(1);
    check("t7_owner2", 32'(owner), 32'd2);
    tick(1);
    #1 reset = 1'b0;
    #1;
    check("t7_async_grnt", 32'(m_grnt_), 32'h0000000f);
    m_req_ = 4'b1100;
    tick(1);
    reset = 1'b1;
    tick(1);
    check("t7_first_owner", 32'(owner),   32'd1);
    check("t7_first_grnt",  32'(m_grnt_), 32'h0000000d);
    m_req_ = 4'b1111;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
